pc_fetch_unit: RTL and testbench
================================

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 SHALL have parameter DWIDTH, default 32, instruction/PC width.
REQ-002 SHALL have parameter AWIDTH, default 8, instruction-memory byte-address width.
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address.
REQ-004 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port STALL  input  1  hold PC and state this cycle.
REQ-007 SHALL have port REDIRECT  input  1  taken branch/jump; next PC = TARGET.
REQ-008 SHALL have port TARGET  input  DWIDTH  redirect byte address.
REQ-009 SHALL have port IMEM_A  output  AWIDTH  instruction-memory address.
REQ-010 SHALL have port IMEM_RD  input  DWIDTH  instruction-memory read data, combinational from IMEM_A.
REQ-011 SHALL have port PC  output  DWIDTH  current PC.
REQ-012 SHALL have port PC_PLUS4  output  DWIDTH  PC + 4, modulo 2^DWIDTH.
REQ-013 SHALL have port INSTR  output  DWIDTH  instruction issued to decode.
REQ-014 SHALL have port INSTR_VALID  output  1  INSTR is a real fetched instruction.
REQ-015 SHALL have port HALTED  output  1  core stopped by ECALL/EBREAK.
REQ-016 SHALL have port MISALIGN  output  1  sticky misaligned-redirect trap flag.
REQ-017 SHALL have port RETIRED  output  32  retired-instruction counter.

Function
REQ-018 SHALL implement FSM states BOOT, RUN, HALT, TRAP.
REQ-019 BOOT SHALL last exactly one cycle after reset release, INSTR_VALID=0, PC=RESET_PC, then go to RUN regardless of STALL.
REQ-020 IMEM_A SHALL equal PC[AWIDTH-1:0] in every state (address wrap-around beyond 2^AWIDTH is by truncation).
REQ-021 In RUN, INSTR SHALL equal IMEM_RD and INSTR_VALID SHALL be 1; in BOOT/HALT/TRAP INSTR SHALL be 32'h0000_0013 (NOP) and INSTR_VALID 0.
REQ-022 Next-PC priority in RUN SHALL be: STALL (hold) > halt detect > misalign check > REDIRECT (TARGET) > sequential (PC_PLUS4).
REQ-023 If INSTR is 32'h0000_0073 (ECALL) or 32'h0010_0073 (EBREAK) in RUN with STALL=0, that instruction SHALL retire, PC SHALL hold, and the FSM SHALL enter HALT next cycle; a same-cycle REDIRECT is ignored.
REQ-024 If REDIRECT=1 and TARGET[1:0]!=0 in RUN with STALL=0, PC SHALL hold, the instruction SHALL still retire, MISALIGN SHALL set, and the FSM SHALL enter TRAP next cycle.
REQ-025 PC SHALL wrap from 32'hFFFF_FFFC to 32'h0000_0000 on sequential advance.
REQ-026 RETIRED SHALL increment by 1 on every RUN cycle with STALL=0, wrapping at 2^32, and never in other states.
REQ-027 HALT and TRAP SHALL be absorbing; only RST leaves them; STALL/REDIRECT have no effect there.
REQ-028 HALTED SHALL be 1 exactly while in HALT; MISALIGN SHALL be 1 from TRAP entry until reset.
REQ-029 PC_PLUS4 SHALL be combinational from PC with zero latency.

Reset
REQ-030 On RST=1, immediately and regardless of CLK: state=BOOT, PC=RESET_PC, RETIRED=0, MISALIGN=0, HALTED=0, INSTR_VALID=0, INSTR=NOP.
REQ-031 RST asserted mid-operation (any state, including during STALL) SHALL abandon the current instruction without retiring it.
REQ-032 RESET_PC with bits [1:0]!=0 SHALL be an elaboration error.

Structure
REQ-033 A shared package SHALL hold the FSM state enum, NOP/ECALL/EBREAK encodings, and the reset-vector default.
REQ-034 One sub-module, pc_next_sel, SHALL hold the combinational next-PC priority mux and misalign/halt detection; PC register, FSM and counter stay in pc_fetch_unit.

Verification
REQ-035 Reset release, STALL=0, REDIRECT=0 -> cycle 0 BOOT (INSTR_VALID=0), then PC 0x00,0x04,0x08; RETIRED=3 after three RUN cycles.
REQ-036 At PC=0x08, STALL=1 for 2 cycles with REDIRECT=1, TARGET=0x40 -> PC stays 0x08, RETIRED unchanged; after STALL drops, next PC follows REDIRECT.
REQ-037 At PC=0x04, REDIRECT=1, TARGET=0x20 -> next PC=0x20, IMEM_A=8'h20; TARGET=0x102 with AWIDTH=8 -> MISALIGN=1, TRAP, PC stays 0x04.
REQ-038 IMEM_RD=32'h0010_0073 at PC=0x0C -> RETIRED increments once, HALTED=1 next cycle, PC stays 0x0C, INSTR=NOP thereafter.
REQ-039 PC forced to 0xFFFF_FFFC via TARGET, sequential advance -> PC=0x0000_0000; RETIRED preloaded near 0xFFFF_FFFF wraps to 0.
REQ-040 RST pulsed asynchronously between edges while in HALT -> outputs reach reset values before next edge, BOOT follows release.

Source files
------------

// File: rtl/pc_fetch_unit_pkg.sv
// pc_fetch_unit_pkg
// Purpose: shared definitions for the PC fetch unit -- FSM state encoding,
//          the fixed RV32 instruction encodings the fetch unit must recognise
//          or inject, and the default reset vector.
// Ports:   none (package).
package pc_fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2,
    ST_TRAP = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;  // addi x0, x0, 0
  localparam logic [31:0] ECALL_INSTR  = 32'h0000_0073;
  localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;
  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

  // True for the two system instructions that stop the core.
  function automatic logic is_halt_instr(input logic [31:0] instr);
    return (instr == ECALL_INSTR) || (instr == EBREAK_INSTR);
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// pc_next_sel
// Purpose: combinational next-PC selection for a running core, including
//          halt (ECALL/EBREAK) and misaligned-redirect detection. The result
//          is only meaningful while the fetch FSM is in RUN.
// Ports:
//   i_pc, i_pc_plus4 : current PC and its sequential successor
//   i_instr          : instruction currently being issued
//   i_stall          : hold request (highest priority)
//   i_redirect       : taken branch/jump request
//   i_target         : redirect byte address
//   o_next_pc        : selected next PC (equals i_pc on hold/halt/misalign)
//   o_halt           : a halting instruction is retiring this cycle
//   o_misalign       : a misaligned redirect is retiring this cycle
module pc_next_sel
  import pc_fetch_unit_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic [DWIDTH-1:0] i_pc,
  input  logic [DWIDTH-1:0] i_pc_plus4,
  input  logic [DWIDTH-1:0] i_instr,
  input  logic              i_stall,
  input  logic              i_redirect,
  input  logic [DWIDTH-1:0] i_target,
  output logic [DWIDTH-1:0] o_next_pc,
  output logic              o_halt,
  output logic              o_misalign
);

  // Priority: stall > halt > misaligned redirect > redirect > sequential.
  always_comb begin
    o_next_pc  = i_pc;
    o_halt     = 1'b0;
    o_misalign = 1'b0;
    if (i_stall) begin
      o_next_pc = i_pc;
    end else if (is_halt_instr(32'(i_instr))) begin
      o_halt = 1'b1;
    end else if (i_redirect && (i_target[1:0] != 2'b00)) begin
      o_misalign = 1'b1;
    end else if (i_redirect) begin
      o_next_pc = i_target;
    end else begin
      o_next_pc = i_pc_plus4;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
// Purpose: program-counter and instruction-fetch front end. Owns the PC
//          register, the BOOT/RUN/HALT/TRAP FSM, the sticky misalign flag
//          and the retired-instruction counter.
// Ports:
//   CLK, RST        : clock, asynchronous active-high reset
//   STALL           : hold PC and state this cycle
//   REDIRECT/TARGET : taken branch/jump and its byte address
//   IMEM_A/IMEM_RD  : instruction memory address / combinational read data
//   PC, PC_PLUS4    : current PC and PC + 4
//   INSTR           : instruction to decode (NOP when not valid)
//   INSTR_VALID     : INSTR is a real fetched instruction
//   HALTED          : core stopped by ECALL/EBREAK
//   MISALIGN        : sticky misaligned-redirect trap flag
//   RETIRED         : retired-instruction counter
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int                DWIDTH   = 32,
  parameter int                AWIDTH   = 8,
  parameter logic [DWIDTH-1:0] RESET_PC = DWIDTH'(RESET_VECTOR)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              STALL,
  input  logic              REDIRECT,
  input  logic [DWIDTH-1:0] TARGET,
  output logic [AWIDTH-1:0] IMEM_A,
  input  logic [DWIDTH-1:0] IMEM_RD,
  output logic [DWIDTH-1:0] PC,
  output logic [DWIDTH-1:0] PC_PLUS4,
  output logic [DWIDTH-1:0] INSTR,
  output logic              INSTR_VALID,
  output logic              HALTED,
  output logic              MISALIGN,
  output logic [31:0]       RETIRED
);

  if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
    $error("pc_fetch_unit: RESET_PC must be word aligned");
  end

  fetch_state_e      r_state;
  fetch_state_e      w_state_next;
  logic [DWIDTH-1:0] r_pc;
  logic [DWIDTH-1:0] w_pc_next;
  logic [DWIDTH-1:0] w_pc_plus4;
  logic [DWIDTH-1:0] w_sel_pc;
  logic [31:0]       r_retired;
  logic              r_misalign;
  logic              r_halted;
  logic              r_instr_valid;
  logic              w_retire;
  logic              w_enter_trap;
  logic              w_sel_halt;
  logic              w_sel_misalign;

  assign w_pc_plus4 = r_pc + DWIDTH'(4);

  pc_next_sel #(
    .DWIDTH (DWIDTH)
  ) u_next_sel (
    .i_pc       (r_pc),
    .i_pc_plus4 (w_pc_plus4),
    .i_instr    (IMEM_RD),
    .i_stall    (STALL),
    .i_redirect (REDIRECT),
    .i_target   (TARGET),
    .o_next_pc  (w_sel_pc),
    .o_halt     (w_sel_halt),
    .o_misalign (w_sel_misalign)
  );

  // Next-state, next-PC and retire decision.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_retire     = 1'b0;
    w_enter_trap = 1'b0;
    case (r_state)
      ST_BOOT: begin
        w_state_next = ST_RUN;
      end
      ST_RUN: begin
        if (!STALL) begin
          // Halting and trapping instructions still retire; the selector
          // already holds the PC for them.
          w_retire  = 1'b1;
          w_pc_next = w_sel_pc;
          if (w_sel_halt) begin
            w_state_next = ST_HALT;
          end else if (w_sel_misalign) begin
            w_state_next = ST_TRAP;
            w_enter_trap = 1'b1;
          end else begin
            w_state_next = ST_RUN;
          end
        end else begin
          w_state_next = ST_RUN;
        end
      end
      ST_HALT: begin
        w_state_next = ST_HALT;
      end
      ST_TRAP: begin
        w_state_next = ST_TRAP;
      end
      default: begin
        w_state_next = ST_BOOT;
      end
    endcase
  end

  // FSM state register with registered state-decoded flags.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state       <= ST_BOOT;
      r_halted      <= 1'b0;
      r_instr_valid <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_halted      <= (w_state_next == ST_HALT);
      r_instr_valid <= (w_state_next == ST_RUN);
    end
  end

  // PC, retired counter and sticky misalign flag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_pc       <= RESET_PC;
      r_retired  <= 32'd0;
      r_misalign <= 1'b0;
    end else begin
      r_pc       <= w_pc_next;
      r_retired  <= w_retire ? (r_retired + 32'd1) : r_retired;
      r_misalign <= r_misalign | w_enter_trap;
    end
  end

  assign IMEM_A      = r_pc[AWIDTH-1:0];
  assign PC          = r_pc;
  assign PC_PLUS4    = w_pc_plus4;
  assign INSTR       = r_instr_valid ? IMEM_RD : DWIDTH'(NOP_INSTR);
  assign INSTR_VALID = r_instr_valid;
  assign HALTED      = r_halted;
  assign MISALIGN    = r_misalign;
  assign RETIRED     = r_retired;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit
// Purpose: self-checking bench for pc_fetch_unit. A behavioural model tracks
//          mode, PC, retire count and trap flag from the architectural rules;
//          a compare process checks every output on each falling edge, and
//          directed literal checks pin the model at key points.
module tb_pc_fetch_unit;

  localparam int M_BOOT = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;
  localparam int M_TRAP = 3;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] target;
  logic [7:0]  imem_a;
  logic [31:0] imem_rd;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] instr;
  logic        instr_valid;
  logic        halted;
  logic        misalign;
  logic [31:0] retired;

  logic [31:0] mem [0:63];

  int          n_cmp;
  int          n_bad;
  logic        chk_en;

  int          m_mode;
  logic [31:0] m_pc;
  logic [31:0] m_ret;
  logic        m_mis;
  logic        pre_req;
  logic [31:0] pre_val;

  pc_fetch_unit dut (
    .CLK         (clk),
    .RST         (rst),
    .STALL       (stall),
    .REDIRECT    (redirect),
    .TARGET      (target),
    .IMEM_A      (imem_a),
    .IMEM_RD     (imem_rd),
    .PC          (pc),
    .PC_PLUS4    (pc_plus4),
    .INSTR       (instr),
    .INSTR_VALID (instr_valid),
    .HALTED      (halted),
    .MISALIGN    (misalign),
    .RETIRED     (retired)
  );

  assign imem_rd = mem[imem_a[7:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] addr);
    return mem[addr[7:2]];
  endfunction

  function automatic logic is_sys(input logic [31:0] w);
    return (w == 32'h0000_0073) || (w == 32'h0010_0073);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: architectural effect of each clock edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode <= M_BOOT;
      m_pc   <= 32'h0000_0000;
      m_ret  <= 32'd0;
      m_mis  <= 1'b0;
    end else begin
      case (m_mode)
        M_BOOT: m_mode <= M_RUN;
        M_RUN: begin
          if (!stall) begin
            m_ret <= m_ret + 32'd1;
            if (is_sys(word_at(m_pc))) begin
              m_mode <= M_HALT;
            end else if (redirect && (target % 32'd4 != 32'd0)) begin
              m_mode <= M_TRAP;
              m_mis  <= 1'b1;
            end else if (redirect) begin
              m_pc <= target;
            end else begin
              m_pc <= m_pc + 32'd4;
            end
          end
        end
        default: ;
      endcase
      if (pre_req) m_ret <= pre_val;
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("cyc_pc",       pc,                    m_pc);
      chk("cyc_pc_plus4", pc_plus4,              m_pc + 32'd4);
      chk("cyc_imem_a",   {24'h0, imem_a},       {24'h0, m_pc[7:0]});
      chk("cyc_valid",    {31'h0, instr_valid},  {31'h0, m_mode == M_RUN});
      chk("cyc_instr",    instr,                 (m_mode == M_RUN) ? word_at(m_pc) : 32'h0000_0013);
      chk("cyc_halted",   {31'h0, halted},       {31'h0, m_mode == M_HALT});
      chk("cyc_misalign", {31'h0, misalign},     {31'h0, m_mis});
      chk("cyc_retired",  retired,               m_ret);
    end
  end

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    chk_en   = 1'b0;
    pre_req  = 1'b0;
    pre_val  = 32'd0;
    rst      = 1'b1;
    stall    = 1'b0;
    redirect = 1'b0;
    target   = 32'd0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0013 | (32'(i) << 20);
    mem[3] = 32'h0010_0073;  // EBREAK at 0x0C

    // Reset values before any clock edge.
    #2;
    chk("rst_pc",      pc,                   32'h0);
    chk("rst_retired", retired,              32'h0);
    chk("rst_instr",   instr,                32'h0000_0013);
    chk("rst_valid",   {31'h0, instr_valid}, 32'h0);
    chk("rst_halted",  {31'h0, halted},      32'h0);
    chk("rst_mis",     {31'h0, misalign},    32'h0);

    @(negedge clk); rst = 1'b0; chk_en = 1'b1;
    #1;
    chk("boot_valid", {31'h0, instr_valid}, 32'h0);
    chk("boot_pc",    pc,                   32'h0);

    // Sequential fetch from the reset vector.
    @(negedge clk);
    chk("run0_pc",    pc,                   32'h0);
    chk("run0_valid", {31'h0, instr_valid}, 32'h1);
    chk("run0_instr", instr,                32'h0000_0013);
    @(negedge clk);
    chk("run1_pc",    pc,      32'h4);
    chk("run1_ret",   retired, 32'd1);
    chk("run1_instr", instr,   32'h0010_0013);
    @(negedge clk);
    chk("run2_pc",  pc,      32'h8);
    chk("run2_ret", retired, 32'd2);

    // Stall with a pending redirect: hold, then follow the redirect.
    stall = 1'b1; redirect = 1'b1; target = 32'h40;
    @(negedge clk);
    chk("stall1_pc",  pc,      32'h8);
    chk("stall1_ret", retired, 32'd2);
    @(negedge clk);
    chk("stall2_pc",  pc,      32'h8);
    chk("stall2_ret", retired, 32'd2);
    stall = 1'b0;
    @(negedge clk);
    chk("redir_pc",  pc,      32'h40);
    chk("redir_ret", retired, 32'd3);

    target = 32'h04;
    @(negedge clk);
    chk("redir4_pc", pc, 32'h4);
    target = 32'h20;
    @(negedge clk);
    chk("redir20_pc",  pc,              32'h20);
    chk("redir20_a",   {24'h0, imem_a}, 32'h20);
    chk("redir20_ret", retired,         32'd5);

    // PC wrap at the top of the address space.
    target = 32'hFFFF_FFFC;
    @(negedge clk);
    chk("top_pc",    pc,              32'hFFFF_FFFC);
    chk("top_plus4", pc_plus4,        32'h0);
    chk("top_a",     {24'h0, imem_a}, 32'hFC);
    redirect = 1'b0;
    @(negedge clk);
    chk("wrap_pc",  pc,      32'h0);
    chk("wrap_ret", retired, 32'd7);

    // Preload the retire counter near its limit and let it wrap.
    stall = 1'b1;
    #1;
    force dut.r_retired = 32'hFFFF_FFFE;
    pre_val = 32'hFFFF_FFFE; pre_req = 1'b1;
    @(negedge clk);
    chk("pre_ret", retired, 32'hFFFF_FFFE);
    #1;
    release dut.r_retired;
    pre_req = 1'b0; stall = 1'b0;
    @(negedge clk);
    chk("ret_max", retired, 32'hFFFF_FFFF);
    chk("ret_max_pc", pc,   32'h4);
    @(negedge clk);
    chk("ret_wrap", retired, 32'h0);
    chk("ret_wrap_pc", pc,   32'h8);

    // EBREAK at 0x0C halts; the same-cycle redirect is ignored.
    @(negedge clk);
    chk("ebrk_pc",    pc,      32'hC);
    chk("ebrk_instr", instr,   32'h0010_0073);
    redirect = 1'b1; target = 32'h80;
    @(negedge clk);
    chk("halt_flag",  {31'h0, halted},      32'h1);
    chk("halt_pc",    pc,                   32'hC);
    chk("halt_ret",   retired,              32'd2);
    chk("halt_instr", instr,                32'h0000_0013);
    chk("halt_valid", {31'h0, instr_valid}, 32'h0);
    stall = 1'b1;
    @(negedge clk);
    chk("halt_hold_pc", pc, 32'hC);
    stall = 1'b0; redirect = 1'b0;

    // Asynchronous reset pulse between edges while halted.
    #1; rst = 1'b1;
    #1;
    chk("arst_pc",     pc,                   32'h0);
    chk("arst_ret",    retired,              32'h0);
    chk("arst_halted", {31'h0, halted},      32'h0);
    chk("arst_valid",  {31'h0, instr_valid}, 32'h0);
    chk("arst_instr",  instr,                32'h0000_0013);
    #1; rst = 1'b0;
    #1;
    chk("arst_boot_valid", {31'h0, instr_valid}, 32'h0);
    @(negedge clk);
    chk("arst_run_pc",    pc,                   32'h0);
    chk("arst_run_valid", {31'h0, instr_valid}, 32'h1);
    @(negedge clk);
    chk("pre_mis_pc", pc, 32'h4);

    // Misaligned redirect traps and holds the PC.
    redirect = 1'b1; target = 32'h102;
    @(negedge clk);
    chk("mis_flag",  {31'h0, misalign},    32'h1);
    chk("mis_pc",    pc,                   32'h4);
    chk("mis_ret",   retired,              32'd2);
    chk("mis_valid", {31'h0, instr_valid}, 32'h0);
    target = 32'h20;
    @(negedge clk);
    chk("trap_hold_pc",  pc,      32'h4);
    chk("trap_hold_ret", retired, 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
